// File: rtl/gun_turret.sv
// rtl/gun_turret.sv - player gun turret: movement, projectile slots and pixel overlay
module gun_turret #(
    parameter int          H_ACTIVE   = 640,
    parameter int          GUN_W      = 63,
    parameter int          BARREL_OFS = 26,
    parameter int          BARREL_W   = 11,
    parameter int          BARREL_Y   = 435,
    parameter int          BASE_Y     = 466,
    parameter int          MOVE_DIV   = 50000,
    parameter int          SHOT_DIV   = 20000,
    parameter int          N_SHOTS    = 4,
    parameter int          SHOT_W     = 3,
    parameter int          SHOT_H     = 8,
    parameter int          COOLDOWN   = 16,
    parameter logic [5:0]  GUN_COLOR  = 6'h00,
    parameter logic [5:0]  SHOT_COLOR = 6'h3F
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         hcount,
    input  logic [9:0]         vcount,
    input  logic               izq,
    input  logic               der,
    input  logic               fire,
    output logic [5:0]         data,
    output logic               draw,
    output logic [9:0]         pos_x,
    output logic [N_SHOTS-1:0] shot_active,
    output logic               shot_fired
);

    localparam int MOVE_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int SHOT_CW = (SHOT_DIV > 1) ? $clog2(SHOT_DIV) : 1;
    localparam int COOL_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [9:0]  OFS_MAX   = 10'(H_ACTIVE - GUN_W);
    localparam logic [9:0]  SHOT_Y0   = 10'(BARREL_Y - SHOT_H);
    localparam logic [9:0]  SHOT_XOFS = 10'(BARREL_OFS + (BARREL_W - SHOT_W) / 2);
    localparam logic [10:0] BASE_END  = 11'd479;

    logic [9:0]         offset_q, offset_d;
    logic [MOVE_W-1:0]  move_cnt_q, move_cnt_d;
    logic [SHOT_CW-1:0] shot_cnt_q, shot_cnt_d;
    logic [COOL_W-1:0]  cooldown_q, cooldown_d;
    logic               fire_prev_q, fire_prev_d;
    logic [N_SHOTS-1:0] shot_active_q, shot_active_d;
    logic [9:0]         shot_x_q [N_SHOTS];
    logic [9:0]         shot_x_d [N_SHOTS];
    logic [9:0]         shot_y_q [N_SHOTS];
    logic [9:0]         shot_y_d [N_SHOTS];
    logic               shot_fired_q, shot_fired_d;
    logic               draw_q, draw_d;
    logic [5:0]         data_q, data_d;
    logic [9:0]         pos_x_q, pos_x_d;

    logic               move_wrap, shot_tick, fire_edge, slot_found, launch;
    logic [N_SHOTS-1:0] launch_oh;
    logic [10:0]        hc, vc, ofs11, barrel_l, shot_l, shot_t;
    logic               barrel_hit, base_hit, shot_hit;

    always_comb begin
        offset_d      = offset_q;
        move_cnt_d    = move_cnt_q;
        shot_cnt_d    = shot_cnt_q;
        cooldown_d    = cooldown_q;
        fire_prev_d   = fire;
        shot_active_d = shot_active_q;
        shot_x_d      = shot_x_q;
        shot_y_d      = shot_y_q;
        shot_fired_d  = 1'b0;
        launch_oh     = '0;
        slot_found    = 1'b0;
        shot_hit      = 1'b0;
        shot_l        = '0;
        shot_t        = '0;

        move_wrap  = (move_cnt_q == MOVE_W'(MOVE_DIV - 1));
        move_cnt_d = move_wrap ? '0 : move_cnt_q + 1'b1;
        shot_tick  = (shot_cnt_q == SHOT_CW'(SHOT_DIV - 1));
        shot_cnt_d = shot_tick ? '0 : shot_cnt_q + 1'b1;

        // izq takes precedence even when it cannot move, so both-high at the left stop holds
        if (move_wrap) begin
            if (izq) begin
                if (offset_q != 10'd0) offset_d = offset_q - 10'd1;
            end else if (der) begin
                if (offset_q < OFS_MAX) offset_d = offset_q + 10'd1;
            end
        end

        fire_edge = fire & ~fire_prev_q;
        for (int i = 0; i < N_SHOTS; i++) begin
            if (!slot_found && !shot_active_q[i]) begin
                launch_oh[i] = 1'b1;
                slot_found   = 1'b1;
            end
        end
        launch = fire_edge && (cooldown_q == '0) && slot_found;

        if (launch) begin
            cooldown_d   = COOL_W'(COOLDOWN);
            shot_fired_d = 1'b1;
        end else if (shot_tick && cooldown_q != '0) begin
            cooldown_d = cooldown_q - 1'b1;
        end

        for (int i = 0; i < N_SHOTS; i++) begin
            if (launch && launch_oh[i]) begin
                shot_active_d[i] = 1'b1;
                shot_x_d[i]      = offset_q + SHOT_XOFS;
                shot_y_d[i]      = SHOT_Y0;
            end else if (shot_tick && shot_active_q[i]) begin
                if (shot_y_q[i] == 10'd0) shot_active_d[i] = 1'b0;
                else                      shot_y_d[i] = shot_y_q[i] - 10'd1;
            end
        end

        hc       = {1'b0, hcount};
        vc       = {1'b0, vcount};
        ofs11    = {1'b0, offset_q};
        barrel_l = ofs11 + 11'(BARREL_OFS);
        barrel_hit = (vc >= 11'(BARREL_Y)) && (vc < 11'(BASE_Y)) &&
                     (hc >= barrel_l) && (hc < barrel_l + 11'(BARREL_W));
        base_hit   = (vc >= 11'(BASE_Y)) && (vc <= BASE_END) &&
                     (hc >= ofs11) && (hc < ofs11 + 11'(GUN_W));
        for (int i = 0; i < N_SHOTS; i++) begin
            shot_l = {1'b0, shot_x_q[i]};
            shot_t = {1'b0, shot_y_q[i]};
            if (shot_active_q[i] &&
                (hc >= shot_l) && (hc <= shot_l + 11'(SHOT_W - 1)) &&
                (vc >= shot_t) && (vc <= shot_t + 11'(SHOT_H - 1)))
                shot_hit = 1'b1;
        end

        draw_d  = shot_hit | barrel_hit | base_hit;
        data_d  = shot_hit ? SHOT_COLOR : ((barrel_hit | base_hit) ? GUN_COLOR : 6'h00);
        pos_x_d = offset_d + 10'(BARREL_OFS);

        // fire history tracks the button through reset so a held press cannot launch on release
        if (reset) begin
            offset_d      = '0;
            move_cnt_d    = '0;
            shot_cnt_d    = '0;
            cooldown_d    = '0;
            shot_active_d = '0;
            for (int i = 0; i < N_SHOTS; i++) begin
                shot_x_d[i] = '0;
                shot_y_d[i] = '0;
            end
            shot_fired_d = 1'b0;
            draw_d       = 1'b0;
            data_d       = 6'h00;
            pos_x_d      = 10'(BARREL_OFS);
        end
    end

    always_ff @(posedge clk) begin
        offset_q      <= offset_d;
        move_cnt_q    <= move_cnt_d;
        shot_cnt_q    <= shot_cnt_d;
        cooldown_q    <= cooldown_d;
        fire_prev_q   <= fire_prev_d;
        shot_active_q <= shot_active_d;
        for (int i = 0; i < N_SHOTS; i++) begin
            shot_x_q[i] <= shot_x_d[i];
            shot_y_q[i] <= shot_y_d[i];
        end
        shot_fired_q  <= shot_fired_d;
        draw_q        <= draw_d;
        data_q        <= data_d;
        pos_x_q       <= pos_x_d;
    end

    assign data        = data_q;
    assign draw        = draw_q;
    assign pos_x       = pos_x_q;
    assign shot_active = shot_active_q;
    assign shot_fired  = shot_fired_q;

endmodule

// File: tb/tb_gun_turret.sv
// tb/tb_gun_turret.sv - directed bench for gun_turret with fast move/shot dividers
module tb_gun_turret;

    logic       clk = 1'b0;
    logic       reset, izq, der, fire;
    logic [9:0] hcount, vcount;
    logic [5:0] data;
    logic       draw;
    logic [9:0] pos_x;
    logic [3:0] shot_active;
    logic       shot_fired;

    gun_turret #(
        .MOVE_DIV (4),
        .SHOT_DIV (4),
        .COOLDOWN (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .izq         (izq),
        .der         (der),
        .fire        (fire),
        .data        (data),
        .draw        (draw),
        .pos_x       (pos_x),
        .shot_active (shot_active),
        .shot_fired  (shot_fired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] hc;
        logic [9:0] vc;
        logic       exp_draw;
        logic [5:0] exp_data;
    } pix_vec_t;

    pix_vec_t pv [13];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_fire(output logic fired);
        fire = 1'b1;
        step(1);
        fired = shot_fired;
        fire = 1'b0;
        step(1);
    endtask

    task automatic wait_slot_free(input int slot, input int budget, output logic ok);
        int n;
        n = 0;
        while (shot_active[slot] !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
        ok = (shot_active[slot] === 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic f, ok;
        int   n, cyc;

        pv[0]  = '{10'd130, 10'd430, 1'b1, 6'h3F};
        pv[1]  = '{10'd129, 10'd430, 1'b0, 6'h00};
        pv[2]  = '{10'd132, 10'd430, 1'b1, 6'h3F};
        pv[3]  = '{10'd133, 10'd430, 1'b0, 6'h00};
        pv[4]  = '{10'd126, 10'd435, 1'b1, 6'h00};
        pv[5]  = '{10'd125, 10'd440, 1'b0, 6'h00};
        pv[6]  = '{10'd136, 10'd465, 1'b1, 6'h00};
        pv[7]  = '{10'd137, 10'd440, 1'b0, 6'h00};
        pv[8]  = '{10'd100, 10'd466, 1'b1, 6'h00};
        pv[9]  = '{10'd99,  10'd470, 1'b0, 6'h00};
        pv[10] = '{10'd162, 10'd479, 1'b1, 6'h00};
        pv[11] = '{10'd163, 10'd470, 1'b0, 6'h00};
        pv[12] = '{10'd150, 10'd480, 1'b0, 6'h00};

        reset = 1'b1; izq = 1'b0; der = 1'b0; fire = 1'b0;
        hcount = 10'd0; vcount = 10'd0;
        step(3);
        reset = 1'b0;
        check("reset_pos_x", pos_x, 26);
        check("reset_draw", draw, 0);
        check("reset_data", data, 0);
        check("reset_active", shot_active, 0);
        check("reset_fired", shot_fired, 0);

        // travel limits and izq priority
        der = 1'b1; step(2400);
        check("right_limit", pos_x, 603);
        der = 1'b0; izq = 1'b1; step(2400);
        check("left_limit", pos_x, 26);
        der = 1'b1; step(20);
        check("both_at_left_hold", pos_x, 26);
        izq = 1'b0; step(40);
        check("der_10_steps", pos_x, 36);
        izq = 1'b1; step(20);
        check("both_decrement", pos_x, 31);
        izq = 1'b0; step(380);
        check("offset_100", pos_x, 126);
        der = 1'b0;

        // single shot launch, flight and expiry
        fire = 1'b1; step(1);
        check("launch_pulse", shot_fired, 1);
        check("launch_x", dut.shot_x_q[0], 130);
        check("launch_y", dut.shot_y_q[0], 427);
        check("launch_slot0", shot_active, 4'b0001);
        fire = 1'b0; step(1);
        check("pulse_one_cycle", shot_fired, 0);
        cyc = 1;
        der = 1'b1; step(40);
        der = 1'b0; izq = 1'b1; step(40);
        izq = 1'b0; cyc += 80;
        check("x_latched", dut.shot_x_q[0], 130);
        check("gun_back_100", pos_x, 126);
        while (dut.shot_y_q[0] != 10'd0 && cyc < 2000) begin
            step(1);
            cyc++;
        end
        check("y_zero_after_427_ticks", (cyc >= 1705 && cyc <= 1708), 1);
        check("active_at_y0", shot_active[0], 1);
        step(3);
        check("active_before_next_tick", shot_active[0], 1);
        step(1);
        check("cleared_next_tick", shot_active[0], 0);

        // held fire gives one launch; cooldown drops early edges
        fire = 1'b1; n = 0;
        repeat (100) begin
            step(1);
            if (shot_fired) n++;
        end
        check("held_fire_one_launch", n, 1);
        check("held_fire_slot0", shot_active, 4'b0001);
        fire = 1'b0; step(1);
        pulse_fire(f);
        check("edge_after_cooldown", f, 1);
        check("fills_slot1", shot_active, 4'b0011);
        pulse_fire(f);
        check("cooldown_drop", f, 0);
        check("cooldown_drop_slots", shot_active, 4'b0011);
        step(12);
        pulse_fire(f);
        check("edge_after_drop", f, 1);
        check("fills_slot2", shot_active, 4'b0111);

        // all slots busy, then refill in the freed slot
        do_reset();
        check("reset2_active", shot_active, 0);
        pulse_fire(f); step(12);
        pulse_fire(f); step(800);
        pulse_fire(f);
        check("three_in_flight", shot_active, 4'b0111);
        wait_slot_free(1, 2000, ok);
        check("slot1_free_timeout", ok, 1);
        check("only_slot2_left", shot_active, 4'b0100);
        pulse_fire(f); step(12);
        check("refill_slot0", shot_active, 4'b0101);
        pulse_fire(f); step(12);
        check("refill_slot1", shot_active, 4'b0111);
        pulse_fire(f); step(12);
        check("fill_slot3", shot_active, 4'b1111);
        pulse_fire(f);
        check("full_drop", f, 0);
        check("full_drop_slots", shot_active, 4'b1111);
        wait_slot_free(2, 2000, ok);
        check("slot2_free_timeout", ok, 1);
        check("slot2_frees_first", shot_active, 4'b1011);
        pulse_fire(f);
        check("refill_pulse", f, 1);
        check("refill_slot2", shot_active, 4'b1111);

        // pixel overlay table
        do_reset();
        der = 1'b1; step(400); der = 1'b0;
        check("pix_offset_100", pos_x, 126);
        pulse_fire(f);
        check("pix_launch", f, 1);
        for (int i = 0; i < 13; i++) begin
            hcount = pv[i].hc;
            vcount = pv[i].vc;
            step(1);
            check($sformatf("pix%0d_draw", i), draw, pv[i].exp_draw);
            check($sformatf("pix%0d_data", i), data, pv[i].exp_data);
        end

        // reset with shots in flight and fire held
        step(12); pulse_fire(f);
        step(12); pulse_fire(f);
        check("pre_reset_three", shot_active, 4'b0111);
        hcount = 10'd0; vcount = 10'd470;
        fire = 1'b1; der = 1'b1; reset = 1'b1;
        step(1);
        check("rst_active", shot_active, 0);
        check("rst_fired", shot_fired, 0);
        check("rst_draw", draw, 0);
        check("rst_data", data, 0);
        check("rst_pos_x", pos_x, 26);
        reset = 1'b0; der = 1'b0; n = 0;
        repeat (20) begin
            step(1);
            if (shot_fired) n++;
        end
        check("held_through_reset_no_launch", n, 0);
        check("held_through_reset_slots", shot_active, 0);
        fire = 1'b0; step(1);
        pulse_fire(f);
        check("retoggle_launch", f, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
